alu_div_seq: RTL and testbench

//  Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, issued from the execute stage beside the combinational ALU.

---
 rtl/alu_div_seq.sv | 212 +++++++++++++++++++++
 tb/tb_alu_div_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU. Busy stalls the pipeline while the divider iterates.
// Done is a one-cycle pulse that marks Result as valid for writeback.
// Optional feature macro: DIV_FAST_PATH_EN. When it is defined, the
// special cases (B=0, signed overflow, A=0, B=1 unsigned) finish at accept
// and skip the CALC and FIX states.
module alu_div_seq #(
    parameter int unsigned DATA_LENGTH = 32
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic                   Start,
    input  logic [1:0]             DivOp,
    input  logic [DATA_LENGTH-1:0] InputA,
    input  logic [DATA_LENGTH-1:0] InputB,
    input  logic                   Flush,
    output logic                   Busy,
    output logic                   Done,
    output logic [DATA_LENGTH-1:0] Result
);

    localparam int unsigned CW = $clog2(DATA_LENGTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]          count;
    logic [DATA_LENGTH-1:0] rem;
    logic [DATA_LENGTH-1:0] quo;
    logic [DATA_LENGTH-1:0] divisor;
    logic [DATA_LENGTH-1:0] a_orig;
    logic                   qsign;
    logic                   rsign;
    logic                   op_rem;

    // Operand decode at accept
    logic                   op_signed;
    logic                   a_neg;
    logic                   b_neg;
    logic [DATA_LENGTH-1:0] abs_a;
    logic [DATA_LENGTH-1:0] abs_b;
    logic                   accepting;
    logic                   start_go;
    logic                   fast_hit;
    logic [DATA_LENGTH-1:0] fast_val;

    // Iteration datapath
    logic [DATA_LENGTH:0]   rem_shift;
    logic                   take;
    logic [DATA_LENGTH-1:0] rem_next;

    // Sign correction / special-case result
    logic [DATA_LENGTH-1:0] q_fix;
    logic [DATA_LENGTH-1:0] r_fix;
    logic [DATA_LENGTH-1:0] fix_val;

    // Operand magnitudes, signs and the accept condition
    always_comb begin
        op_signed = ~DivOp[0];
        a_neg     = op_signed & InputA[DATA_LENGTH-1];
        b_neg     = op_signed & InputB[DATA_LENGTH-1];
        abs_a     = a_neg ? (~InputA + 1'b1) : InputA;
        abs_b     = b_neg ? (~InputB + 1'b1) : InputB;
        accepting = (state == IDLE) || (state == DONE);
        start_go  = accepting && Start && !Flush;
    end

`ifdef DIV_FAST_PATH_EN
    // Special cases resolved at accept time without iterating
    logic b_zero;
    logic b_one;
    logic b_ones;
    logic a_zero;
    logic a_min;

    always_comb begin
        b_zero   = (InputB == '0);
        b_one    = (InputB == DATA_LENGTH'(1));
        b_ones   = (InputB == '1);
        a_zero   = (InputA == '0);
        a_min    = (InputA == {1'b1, {(DATA_LENGTH-1){1'b0}}});
        fast_hit = 1'b0;
        fast_val = '0;
        if (b_zero) begin
            fast_hit = 1'b1;
            fast_val = DivOp[1] ? InputA : '1;
        end else if (op_signed && a_min && b_ones) begin
            fast_hit = 1'b1;
            fast_val = DivOp[1] ? '0 : InputA;
        end else if (a_zero) begin
            fast_hit = 1'b1;
            fast_val = '0;
        end else if (!op_signed && b_one) begin
            fast_hit = 1'b1;
            fast_val = DivOp[1] ? '0 : InputA;
        end
    end
`else
    // Every operation takes the full iterative path
    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
    end
`endif

    // One restoring step: the shifted remainder keeps its carry bit so the
    // compare is exact; the difference always fits in DATA_LENGTH bits.
    always_comb begin
        rem_shift = {rem, quo[DATA_LENGTH-1]};
        take      = (rem_shift >= {1'b0, divisor});
        rem_next  = take ? (rem_shift[DATA_LENGTH-1:0] - divisor)
                         : rem_shift[DATA_LENGTH-1:0];
    end

    // Final sign correction and divide-by-zero override
    always_comb begin
        q_fix = qsign ? (~quo + 1'b1) : quo;
        r_fix = rsign ? (~rem + 1'b1) : rem;
        if (divisor == '0) begin
            fix_val = op_rem ? a_orig : '1;
        end else begin
            fix_val = op_rem ? r_fix : q_fix;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        Busy       = (state == CALC) || (state == FIX);
        Done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start_go) begin
                    state_next = fast_hit ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(DATA_LENGTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (start_go) begin
                    state_next = fast_hit ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (Flush) begin
            state_next = IDLE;
        end
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            a_orig  <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            op_rem  <= 1'b0;
            Result  <= '0;
        end else begin
            if (start_go) begin
                count   <= '0;
                rem     <= '0;
                quo     <= abs_a;
                divisor <= abs_b;
                a_orig  <= InputA;
                qsign   <= a_neg ^ b_neg;
                rsign   <= a_neg;
                op_rem  <= DivOp[1];
                if (fast_hit) begin
                    Result <= fast_val;
                end
            end else if (state == CALC) begin
                rem   <= rem_next;
                quo   <= {quo[DATA_LENGTH-2:0], take};
                count <= count + 1'b1;
            end else if ((state == FIX) && !Flush) begin
                Result <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed and randomized checks of alu_div_seq against a
// plain-arithmetic reference model of RV32M division semantics.
module tb_alu_div_seq;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        Start;
    logic [1:0]  DivOp;
    logic [31:0] InputA;
    logic [31:0] InputB;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    alu_div_seq #(.DATA_LENGTH(32)) dut (
        .Clk    (Clk),
        .RstN   (RstN),
        .Start  (Start),
        .DivOp  (DivOp),
        .InputA (InputA),
        .InputB (InputB),
        .Flush  (Flush),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M results from plain integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Extra edges after the accept edge until Done is visible
    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (a == 32'd0) return 0;
        if (op[0] && b == 32'd1) return 0;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        DivOp  = op;
        InputA = a;
        InputB = b;
        Start  = 1'b1;
    endtask

    // Waits for Done after an issue; optionally pokes Start mid-operation
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat, input bit interfere);
        int lat;
        bit seen;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat   = 0;
        seen  = Done;
        check({tag, "_busy"}, 32'(Busy), (exp_lat == 0) ? 32'd0 : 32'd1);
        while (!seen && lat < 100) begin
            if (interfere && lat == 5) issue(OP_DIVU, 32'd100, 32'd7);
            @(posedge Clk); #1;
            Start = 1'b0;
            lat++;
            seen = Done;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, Result, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag, model(op, a, b), model_lat(op, a, b), 1'b0);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk); #1;
            if (Done) n++;
        end
        check(tag, 32'(n), 32'd0);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;

    initial begin
        RstN   = 1'b0;
        Start  = 1'b0;
        Flush  = 1'b0;
        DivOp  = '0;
        InputA = '0;
        InputB = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_res", Result, 32'd0);
        RstN = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        @(posedge Clk); #1;
        check("done_pulse", 32'(Done), 32'd0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op("rem_by0", OP_REM, 32'hFFFF_FFF9, 32'd0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_min", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_b1", OP_DIVU, 32'hDEAD_BEEF, 32'd1);
        run_op("div_a0", OP_DIV, 32'd0, 32'hFFFF_FFF0);

        // Flush mid-op drops the operation
        issue(OP_DIVU, 32'd1000, 32'd3);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        check("flush_busy", 32'(Busy), 32'd0);
        count_dones("flush_nodone", 40);

        // New op after flush; a second Start while busy is ignored
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done("post_flush", 32'd3, 33, 1'b1);
        count_dones("ignored_start", 40);

        // Flush and Start together: Start is dropped
        issue(OP_DIVU, 32'd50, 32'd5);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_busy", 32'(Busy), 32'd0);
        count_dones("flush_start_nodone", 40);

        // Reset mid-operation clears everything
        issue(OP_DIVU, 32'd1000, 32'd3);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        RstN = 1'b0;
        @(posedge Clk); #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_res", Result, 32'd0);
        RstN = 1'b1;
        count_dones("midrst_nodone", 40);

        // Back-to-back issue in the Done cycle
        run_op("b2b_first", OP_DIV, 32'hFFFF_FF00, 32'd16);
        run_op("b2b_second", OP_REMU, 32'd12345, 32'd100);

        // Randomized operations with special operands mixed in
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = $urandom_range(0, 1000);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 20);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
